// File: rtl/mercury_ddio_pkg.sv
// Shared constants for the Mercury DDIO input and output blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package mercury_ddio_pkg;

  // Sample pairs per deserialized word: default value and legal limits.
  localparam int DESER_PAIRS_DEF = 4;
  localparam int DESER_PAIRS_MIN = 2;
  localparam int DESER_PAIRS_MAX = 16;

  // POWER_UP_MODE strings. Any value other than "high" decodes to 0.
  localparam string PU_MODE_LOW  = "low";
  localparam string PU_MODE_HIGH = "high";

endpackage

// File: rtl/mercury_ddio_in_capture.sv
// DDR pad capture: rising sample, falling sample, then both retimed to rising edge.
// Latency: 2 edges from rising-edge sample to dataout_h/dataout_l/pair_valid.
// Backpressure: none; clkena low holds all data and drops pair_valid one edge later.
// Ports: clk, areset_n (async, active low), clkena, padio in;
//        dataout_h, dataout_l, pair_valid out.
module mercury_ddio_in_capture #(
  parameter logic PU_VAL = 1'b0
) (
  input  logic clk,
  input  logic areset_n,
  input  logic clkena,
  input  logic padio,
  output logic dataout_h,
  output logic dataout_l,
  output logic pair_valid
);

  logic h_reg;
  logic l_neg;
  logic en_reg;

  // Rising-edge sample. en_reg remembers whether this edge opened a pair, so
  // the following falling edge knows whether to take its half.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      h_reg  <= PU_VAL;
      en_reg <= 1'b0;
    end else begin
      en_reg <= clkena;
      if (clkena) begin
        h_reg <= padio;
      end
    end
  end

  // The only falling-edge element in the block.
  always_ff @(negedge clk or negedge areset_n) begin
    if (!areset_n) begin
      l_neg <= PU_VAL;
    end else if (en_reg) begin
      l_neg <= padio;
    end
  end

  // Retime the pair onto the rising edge; outputs hold while no pair is open.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      dataout_h  <= PU_VAL;
      dataout_l  <= PU_VAL;
      pair_valid <= 1'b0;
    end else begin
      pair_valid <= en_reg;
      if (en_reg) begin
        dataout_h <= h_reg;
        dataout_l <= l_neg;
      end
    end
  end

endmodule

// File: rtl/mercury_ddio_in_deser.sv
// DDR input deserializer: packs DESER_PAIRS rise/fall pairs into one word, with bitslip.
// Latency: word_valid one edge after the last pair of a word shows on pair_valid.
// Backpressure: none; clkena gaps just stretch word assembly, bitslip drops one pair.
// Ports: clk, areset_n, clkena, padio, bitslip in; dataout_h, dataout_l,
//        pair_valid, word_out[2*DESER_PAIRS-1:0] (earliest sample in MSB), word_valid out.
module mercury_ddio_in_deser
  import mercury_ddio_pkg::*;
#(
  parameter int    DESER_PAIRS   = DESER_PAIRS_DEF,
  parameter string POWER_UP_MODE = PU_MODE_LOW
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic                     clkena,
  input  logic                     padio,
  input  logic                     bitslip,
  output logic                     dataout_h,
  output logic                     dataout_l,
  output logic                     pair_valid,
  output logic [2*DESER_PAIRS-1:0] word_out,
  output logic                     word_valid
);

  localparam logic             PU_VAL = (POWER_UP_MODE == PU_MODE_HIGH);
  localparam int               W      = 2 * DESER_PAIRS;
  localparam int               CNT_W  = $clog2(DESER_PAIRS);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DESER_PAIRS - 1);

  mercury_ddio_in_capture #(
    .PU_VAL (PU_VAL)
  ) u_capture (
    .clk        (clk),
    .areset_n   (areset_n),
    .clkena     (clkena),
    .padio      (padio),
    .dataout_h  (dataout_h),
    .dataout_l  (dataout_l),
    .pair_valid (pair_valid)
  );

  // Only the first DESER_PAIRS-1 pairs need storing; the last pair is taken
  // straight from the capture outputs when the word completes.
  logic [W-3:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic             advance;
  logic [W-1:0]     next_word;

  // A bitslip on a valid pair discards it outright, including a word's last pair.
  assign advance   = pair_valid & ~bitslip;
  assign next_word = {shreg, dataout_h, dataout_l};

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      shreg      <= {(W-2){PU_VAL}};
      word_out   <= {W{PU_VAL}};
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (advance) begin
        shreg <= next_word[W-3:0];
        if (cnt == LAST) begin
          word_out   <= next_word;
          word_valid <= 1'b1;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
